// File: rtl/mult_div.sv
// mult_div -- multi-cycle multiply/divide unit for the EX stage.
//
// Handles MULT, MULTU, DIV and DIVU. Signed operations run on operand
// magnitudes and the signs are fixed up when the result is written.
// Division is 32-step restoring division, one quotient bit per cycle.
// Division by zero completes in one cycle with {operand_1, 32'hFFFFFFFF}.
//
// Build option: define MULT_DIV_FAST_MUL_EN for a single-cycle registered
// 32x32 product; otherwise multiply is a 32-step shift-add over magnitudes.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   funct      funct field of the instruction in EX
//   operand_1  rs: multiplicand / dividend
//   operand_2  rt: multiplier / divisor
//   flush      abandons the operation in flight (priority over all else)
//   stall      external pipeline stall; holds DONE
//   done       registered result-valid flag
//   result     {hi, lo}: product, or {remainder, quotient}
module mult_div (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  input  logic        flush,
  input  logic        stall,
  output logic        done,
  output logic [63:0] result
);

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic [5:0]  count;
  logic [31:0] a_reg;   // multiplier / dividend, shifts into product low / quotient
  logic [31:0] b_reg;   // multiplicand / divisor magnitude
  logic [31:0] p_reg;   // partial product high / partial remainder
  logic        neg_lo;  // negate product (mul) or quotient (div)
  logic        neg_hi;  // negate remainder (div)

  logic        is_mul;
  logic        is_div;
  logic        is_signed;
  logic [31:0] mag1;
  logic [31:0] mag2;

  logic [32:0] rem_shift;
  logic [33:0] rem_diff;
  logic        rem_ge;
  logic [31:0] div_p;
  logic [31:0] div_a;
  logic [31:0] quo_fin;
  logic [31:0] rem_fin;

  logic [32:0] mul_sum;
  logic [31:0] mul_p;
  logic [31:0] mul_a;
  logic [63:0] mul_res;

`ifdef MULT_DIV_FAST_MUL_EN
  logic [63:0] fast_prod;
`endif

  always_comb begin
    is_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    is_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    mag1      = (is_signed && operand_1[31]) ? -operand_1 : operand_1;
    mag2      = (is_signed && operand_2[31]) ? -operand_2 : operand_2;

    // Restoring division step: shift next dividend bit into the remainder,
    // subtract the divisor if it fits, and shift the outcome in as a quotient bit.
    rem_shift = {p_reg, a_reg[31]};
    rem_diff  = {1'b0, rem_shift} - {2'b00, b_reg};
    rem_ge    = ~rem_diff[33];
    div_p     = rem_ge ? rem_diff[31:0] : rem_shift[31:0];
    div_a     = {a_reg[30:0], rem_ge};
    quo_fin   = neg_lo ? -div_a : div_a;
    rem_fin   = neg_hi ? -div_p : div_p;

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift {carry, p, a} right; after 32 steps {p, a} is the product.
    mul_sum   = {1'b0, p_reg} + (a_reg[0] ? {1'b0, b_reg} : 33'd0);
    mul_p     = mul_sum[32:1];
    mul_a     = {mul_sum[0], a_reg[31:1]};
    mul_res   = neg_lo ? -{mul_p, mul_a} : {mul_p, mul_a};

`ifdef MULT_DIV_FAST_MUL_EN
    fast_prod = $signed({{32{is_signed & operand_1[31]}}, operand_1}) *
                $signed({{32{is_signed & operand_2[31]}}, operand_2});
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= '0;
      count  <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      p_reg  <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mul || is_div) begin
            a_reg  <= mag1;
            b_reg  <= mag2;
            p_reg  <= '0;
            count  <= '0;
            neg_lo <= is_signed & (operand_1[31] ^ operand_2[31]);
            neg_hi <= is_signed & operand_1[31];
            if (is_div && (operand_2 == '0)) begin
              result <= {operand_1, 32'hFFFF_FFFF};
              state  <= DONE;
              done   <= 1'b1;
            end else if (is_div) begin
              state <= DIV;
            end else begin
`ifdef MULT_DIV_FAST_MUL_EN
              result <= fast_prod;
              state  <= DONE;
              done   <= 1'b1;
`else
              state <= MUL;
`endif
            end
          end
        end
        MUL: begin
          a_reg <= mul_a;
          p_reg <= mul_p;
          count <= count + 6'd1;
          if (count == 6'd31) begin
            result <= mul_res;
            state  <= DONE;
            done   <= 1'b1;
          end
        end
        DIV: begin
          a_reg <= div_a;
          p_reg <= div_p;
          count <= count + 6'd1;
          if (count == 6'd31) begin
            result <= {rem_fin, quo_fin};
            state  <= DONE;
            done   <= 1'b1;
          end
        end
        DONE: begin
          if (!stall) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div -- self-checking bench for mult_div: directed vector table,
// hand-written flush/stall/reset/no-start sequences, and random operations
// checked against an arithmetic reference model.
module tb_mult_div;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef MULT_DIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk;
  logic        rst;
  logic [5:0]  funct;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        flush;
  logic        stall;
  logic        done;
  logic [63:0] result;

  int checks   = 0;
  int failures = 0;
  logic [63:0] last_result;

  mult_div dut (
    .clk       (clk),
    .rst       (rst),
    .funct     (funct),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .flush     (flush),
    .stall     (stall),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic sgn;
    sgn = (f == F_MULT) || (f == F_DIV);
    sa  = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    sb  = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    if (f == F_MULT || f == F_MULTU) begin
      p = sa * sb;
      return p;
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int model_lat(input logic [5:0] f, input logic [31:0] b);
    if (f == F_MULT || f == F_MULTU) return MUL_LAT;
    if (b == 32'h0) return 1;
    return 33;
  endfunction

  // Call at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                        input int stall_cycles);
    int lat;
    funct = f; operand_1 = a; operand_2 = b;
    lat = 0;
    @(posedge clk);
    #1;
    // busy-time input churn must be ignored
    funct = F_MULT + 6'($urandom_range(0, 3));
    operand_1 = $urandom; operand_2 = $urandom;
    do begin
      if (lat > 0) @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!done && lat < 100);
    funct = 6'h00;
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s timeout got=no_done exp=done", name);
      return;
    end
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_res"}, result, exp);
    last_result = exp;
    if (stall_cycles > 0) begin
      stall = 1'b1;
      for (int i = 0; i < stall_cycles; i++) begin
        @(posedge clk); @(negedge clk);
        chk({name, "_stall_done"}, 64'(done), 64'd1);
        chk({name, "_stall_res"}, result, exp);
      end
      stall = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    chk({name, "_idle"}, 64'(done), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b0; funct = 6'h00; operand_1 = '0; operand_2 = '0;
    flush = 1'b0; stall = 1'b0; last_result = '0;

    vecs.push_back('{F_MULT,  32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT});
    vecs.push_back('{F_DIVU,  32'd100,       32'd7,        {32'd2, 32'd14},          33});
    vecs.push_back('{F_DIV,   32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33});
    vecs.push_back('{F_DIV,   32'd5,         32'd0,        {32'd5, 32'hFFFF_FFFF},  1});
    vecs.push_back('{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33});
    vecs.push_back('{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33});
    vecs.push_back('{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT});
    vecs.push_back('{F_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, MUL_LAT});
    vecs.push_back('{F_DIVU,  32'hFFFF_FFFF, 32'd1,        {32'd0, 32'hFFFF_FFFF},  33});
    vecs.push_back('{F_DIV,   32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33});
    vecs.push_back('{F_DIVU,  32'd0,         32'd0,        {32'd0, 32'hFFFF_FFFF},  1});

    // reset state
    @(negedge clk);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0);

    // flush at iteration 10 of a DIVU
    funct = F_DIVU; operand_1 = 32'd1000000; operand_2 = 32'd7;
    @(posedge clk); #1 funct = 6'h00;
    repeat (10) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_res", result, last_result);
    run_op("after_flush", F_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, MUL_LAT, 0);

    // flush beats a start in IDLE; non-mult/div funct does nothing
    funct = F_DIV; operand_1 = 32'd5; operand_2 = 32'd0; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; funct = 6'h20;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("nostart_done", 64'(done), 64'd0);
    chk("nostart_res", result, last_result);
    funct = 6'h00;

    // stall held for 3 cycles in DONE
    run_op("stall", F_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 3);

    // asynchronous reset mid-DIV
    funct = F_DIVU; operand_1 = 32'd1000; operand_2 = 32'd3;
    @(posedge clk); #1 funct = 6'h00;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_res", result, 64'd0);
    @(negedge clk) rst = 1'b1;
    run_op("after_rst", F_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

    // random operations against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [5:0] f;
      logic [31:0] a, b;
      f = F_MULT + 6'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", n), f, a, b, model(f, a, b), model_lat(f, b),
             ($urandom_range(0, 4) == 0) ? 2 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
